mem_arbiter: RTL and testbench

//  Shares the single-ported simulation memory (DPI pmem_read/pmem_write) between

---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response channels for the IF and LS requesters plus the memory strobe bus.
// master: arbiter side; slave: requesters and memory model side.
interface mem_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic                  if_req_valid;
   logic                  if_req_ready;
   logic [ADDR_W-1:0]     if_req_addr;
   logic                  if_rsp_valid;
   logic                  if_rsp_ready;
   logic [DATA_W-1:0]     if_rsp_rdata;

   logic                  ls_req_valid;
   logic                  ls_req_ready;
   logic [ADDR_W-1:0]     ls_req_addr;
   logic                  ls_req_we;
   logic [DATA_W-1:0]     ls_req_wdata;
   logic [DATA_W/8-1:0]   ls_req_wmask;
   logic                  ls_rsp_valid;
   logic                  ls_rsp_ready;
   logic [DATA_W-1:0]     ls_rsp_rdata;

   logic                  mem_ce;
   logic                  mem_we;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W/8-1:0]   mem_wmask;
   logic [DATA_W-1:0]     mem_rdata;

   modport master (
      input  if_req_valid, if_req_addr, if_rsp_ready,
      input  ls_req_valid, ls_req_addr, ls_req_we, ls_req_wdata, ls_req_wmask, ls_rsp_ready,
      input  mem_rdata,
      output if_req_ready, if_rsp_valid, if_rsp_rdata,
      output ls_req_ready, ls_rsp_valid, ls_rsp_rdata,
      output mem_ce, mem_we, mem_addr, mem_wdata, mem_wmask
   );

   modport slave (
      output if_req_valid, if_req_addr, if_rsp_ready,
      output ls_req_valid, ls_req_addr, ls_req_we, ls_req_wdata, ls_req_wmask, ls_rsp_ready,
      output mem_rdata,
      input  if_req_ready, if_rsp_valid, if_rsp_rdata,
      input  ls_req_ready, ls_rsp_valid, ls_rsp_rdata,
      input  mem_ce, mem_we, mem_addr, mem_wdata, mem_wmask
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction fetch
// and load/store; one outstanding transaction, programmable extra response latency.
module mem_arbiter #(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter int LATENCY = 1,
   parameter int CNT_W   = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.master bus
);
   localparam int MASK_W = DATA_W / 8;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;
   typedef enum logic {OWN_IF, OWN_LS} owner_t;

   state_t              state_q, state_d;
   owner_t              owner_q, last_q;
   logic [ADDR_W-1:0]   addr_q;
   logic                we_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [MASK_W-1:0]   wmask_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [CNT_W-1:0]    cnt_q;

   logic any_req;
   logic grant_ls;

   assign any_req  = bus.if_req_valid | bus.ls_req_valid;
   // On a tie the requester that did not win last time gets the grant.
   assign grant_ls = bus.ls_req_valid & (~bus.if_req_valid | (last_q == OWN_IF));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         owner_q <= OWN_IF;
         last_q  <= OWN_LS;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         wmask_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (any_req) begin
                  owner_q <= grant_ls ? OWN_LS : OWN_IF;
                  last_q  <= grant_ls ? OWN_LS : OWN_IF;
                  addr_q  <= grant_ls ? bus.ls_req_addr : bus.if_req_addr;
                  we_q    <= grant_ls & bus.ls_req_we;
                  wdata_q <= grant_ls ? bus.ls_req_wdata : '0;
                  wmask_q <= grant_ls ? bus.ls_req_wmask : '0;
               end
            end
            S_ACCESS: begin
               rdata_q <= we_q ? '0 : bus.mem_rdata;
               cnt_q   <= CNT_W'(LATENCY);
            end
            S_WAIT: cnt_q <= cnt_q - 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d          = state_q;
      bus.if_req_ready = 1'b0;
      bus.ls_req_ready = 1'b0;
      bus.if_rsp_valid = 1'b0;
      bus.if_rsp_rdata = '0;
      bus.ls_rsp_valid = 1'b0;
      bus.ls_rsp_rdata = '0;
      bus.mem_ce       = 1'b0;
      bus.mem_we       = 1'b0;
      bus.mem_addr     = '0;
      bus.mem_wdata    = '0;
      bus.mem_wmask    = '0;
      case (state_q)
         S_IDLE: begin
            // Readies are masked while reset is held so every output reads 0.
            if (rst_n && any_req) begin
               bus.ls_req_ready = grant_ls;
               bus.if_req_ready = ~grant_ls;
               state_d          = S_ACCESS;
            end
         end
         S_ACCESS: begin
            bus.mem_ce    = 1'b1;
            bus.mem_we    = we_q;
            bus.mem_addr  = addr_q;
            bus.mem_wdata = wdata_q;
            bus.mem_wmask = wmask_q;
            state_d       = (LATENCY == 0) ? S_RESP : S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q <= CNT_W'(1)) state_d = S_RESP;
         end
         S_RESP: begin
            if (owner_q == OWN_IF) begin
               bus.if_rsp_valid = 1'b1;
               bus.if_rsp_rdata = rdata_q;
               if (bus.if_rsp_ready) state_d = S_IDLE;
            end else begin
               bus.ls_rsp_valid = 1'b1;
               bus.ls_rsp_rdata = rdata_q;
               if (bus.ls_rsp_ready) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed phases plus randomized traffic, checked against a
// transaction-level model of the arbitration order, memory contents and timing.
module tb_mem_arbiter;
   localparam int LAT = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();
   mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b0 ();
   mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b15 ();

   mem_arbiter #(.ADDR_W(64), .DATA_W(64), .LATENCY(LAT), .CNT_W(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.master));
   mem_arbiter #(.ADDR_W(64), .DATA_W(64), .LATENCY(0), .CNT_W(4)) u_l0 (
      .clk(clk), .rst_n(rst_n), .bus(b0.master));
   mem_arbiter #(.ADDR_W(64), .DATA_W(64), .LATENCY(15), .CNT_W(4)) u_l15 (
      .clk(clk), .rst_n(rst_n), .bus(b15.master));

   // Simple read-only memories for the latency-only instances.
   assign b0.mem_rdata  = b0.mem_ce ? ~b0.mem_addr : 64'h0;
   assign b15.mem_rdata = b15.mem_ce ? ~b15.mem_addr : 64'h0;

   int tests = 0;
   int fails = 0;

   logic [63:0] tmem [logic [63:0]];   // memory behind the DUT, written via mem_* outputs
   logic [63:0] rmem [logic [63:0]];   // model's view, written from issued requests
   bit          m_last_ls;

   function automatic logic [63:0] init_val(input logic [63:0] a);
      return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                         input logic [7:0] wm);
      logic [63:0] r;
      r = old;
      for (int i = 0; i < 8; i++)
         if (wm[i]) r[i*8 +: 8] = wd[i*8 +: 8];
      return r;
   endfunction

   function automatic logic [63:0] tmem_rd(input logic [63:0] a);
      return tmem.exists(a) ? tmem[a] : init_val(a);
   endfunction

   function automatic logic [63:0] rmem_rd(input logic [63:0] a);
      return rmem.exists(a) ? rmem[a] : init_val(a);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_if_rdy"}, bus.if_req_ready, 0);
      chk({tag, "_ls_rdy"}, bus.ls_req_ready, 0);
      chk({tag, "_if_rv"}, bus.if_rsp_valid, 0);
      chk({tag, "_ls_rv"}, bus.ls_rsp_valid, 0);
      chk({tag, "_if_rd"}, bus.if_rsp_rdata, 0);
      chk({tag, "_ls_rd"}, bus.ls_rsp_rdata, 0);
      chk({tag, "_ce"}, bus.mem_ce, 0);
      chk({tag, "_we"}, bus.mem_we, 0);
      chk({tag, "_addr"}, bus.mem_addr, 0);
      chk({tag, "_wd"}, bus.mem_wdata, 0);
      chk({tag, "_wm"}, bus.mem_wmask, 0);
   endtask

   // One complete transaction on the LATENCY=1 instance, starting in IDLE.
   task automatic txn(input bit iv, input bit lv, input logic [63:0] ia, input logic [63:0] la,
                      input bit lwe, input logic [63:0] lwd, input logic [7:0] lwm,
                      input int stall);
      bit          g_ls, e_we;
      logic [63:0] e_addr, e_wd, e_rd;
      logic [7:0]  e_wm;
      bus.if_req_valid = iv;
      bus.if_req_addr  = ia;
      bus.ls_req_valid = lv;
      bus.ls_req_addr  = la;
      bus.ls_req_we    = lwe;
      bus.ls_req_wdata = lwd;
      bus.ls_req_wmask = lwm;
      bus.if_rsp_ready = 1'b0;
      bus.ls_rsp_ready = 1'b0;
      #1;
      if (!iv && !lv) begin
         chk("idle_if_rdy", bus.if_req_ready, 0);
         chk("idle_ls_rdy", bus.ls_req_ready, 0);
         tick();
         chk("idle_ce", bus.mem_ce, 0);
         return;
      end
      g_ls      = lv && (!iv || !m_last_ls);
      m_last_ls = g_ls;
      e_we      = g_ls && lwe;
      e_addr    = g_ls ? la : ia;
      e_wd      = g_ls ? lwd : 64'h0;
      e_wm      = g_ls ? lwm : 8'h0;
      e_rd      = e_we ? 64'h0 : rmem_rd(e_addr);
      if (e_we) rmem[e_addr] = merge(rmem_rd(e_addr), e_wd, e_wm);
      chk("grant_if", bus.if_req_ready, !g_ls);
      chk("grant_ls", bus.ls_req_ready, g_ls);

      tick();
      if (g_ls) bus.ls_req_valid = 1'b0;
      else      bus.if_req_valid = 1'b0;
      bus.mem_rdata = (bus.mem_ce && !bus.mem_we) ? tmem_rd(bus.mem_addr) : 64'($urandom);
      #1;
      chk("acc_ce", bus.mem_ce, 1);
      chk("acc_we", bus.mem_we, e_we);
      chk("acc_addr", bus.mem_addr, e_addr);
      chk("acc_wdata", bus.mem_wdata, e_wd);
      chk("acc_wmask", bus.mem_wmask, e_wm);
      chk("acc_if_rdy", bus.if_req_ready, 0);
      chk("acc_ls_rdy", bus.ls_req_ready, 0);
      if (bus.mem_ce && bus.mem_we)
         tmem[bus.mem_addr] = merge(tmem_rd(bus.mem_addr), bus.mem_wdata, bus.mem_wmask);

      for (int w = 0; w < LAT; w++) begin
         tick();
         bus.mem_rdata = 64'($urandom);
         chk("wait_ce", bus.mem_ce, 0);
         chk("wait_if_rv", bus.if_rsp_valid, 0);
         chk("wait_ls_rv", bus.ls_rsp_valid, 0);
         chk("wait_if_rdy", bus.if_req_ready, 0);
         chk("wait_ls_rdy", bus.ls_req_ready, 0);
      end

      for (int s = 0; s <= stall; s++) begin
         tick();
         chk("rsp_if_rv", bus.if_rsp_valid, !g_ls);
         chk("rsp_ls_rv", bus.ls_rsp_valid, g_ls);
         chk("rsp_rdata", g_ls ? bus.ls_rsp_rdata : bus.if_rsp_rdata, e_rd);
         chk("rsp_ce", bus.mem_ce, 0);
         chk("rsp_if_rdy", bus.if_req_ready, 0);
         chk("rsp_ls_rdy", bus.ls_req_ready, 0);
      end
      if (g_ls) bus.ls_rsp_ready = 1'b1;
      else      bus.if_rsp_ready = 1'b1;
      #1;
      chk("hs_valid", g_ls ? bus.ls_rsp_valid : bus.if_rsp_valid, 1);
      tick();
      bus.if_rsp_ready = 1'b0;
      bus.ls_rsp_ready = 1'b0;
      chk("post_if_rv", bus.if_rsp_valid, 0);
      chk("post_ls_rv", bus.ls_rsp_valid, 0);
   endtask

   initial begin
      logic [63:0] a_w;
      int          lat0, lat15;
      logic [63:0] rd0, rd15;

      bus.if_req_valid = 1'b1; bus.if_req_addr = 64'h8000_0000;
      bus.ls_req_valid = 1'b1; bus.ls_req_addr = 64'h8000_0008;
      bus.ls_req_we = 1'b0; bus.ls_req_wdata = '0; bus.ls_req_wmask = '0;
      bus.if_rsp_ready = 1'b0; bus.ls_rsp_ready = 1'b0; bus.mem_rdata = '0;
      b0.if_req_valid = 1'b0; b0.if_req_addr = '0; b0.if_rsp_ready = 1'b1;
      b0.ls_req_valid = 1'b0; b0.ls_req_addr = '0; b0.ls_req_we = 1'b0;
      b0.ls_req_wdata = '0; b0.ls_req_wmask = '0; b0.ls_rsp_ready = 1'b1;
      b15.if_req_valid = 1'b0; b15.if_req_addr = '0; b15.if_rsp_ready = 1'b1;
      b15.ls_req_valid = 1'b0; b15.ls_req_addr = '0; b15.ls_req_we = 1'b0;
      b15.ls_req_wdata = '0; b15.ls_req_wmask = '0; b15.ls_rsp_ready = 1'b1;
      m_last_ls = 1'b1;

      // Reset held with both requesters valid.
      tick(); tick();
      chk_all_zero("reset");
      rst_n = 1'b1;

      // First tie goes to IF.
      txn(1, 1, 64'h8000_0000, 64'h8000_0008, 0, 0, 0, 0);

      // LS partial write then read-back of the same word.
      txn(0, 1, 0, 64'h8000_0010, 1, 64'hDEAD_BEEF_0000_1111, 8'h0F, 0);
      txn(0, 1, 0, 64'h8000_0010, 0, 0, 0, 1);

      // Continuous contention alternates owners.
      for (int k = 0; k < 4; k++)
         txn(1, 1, 64'h8000_0020 + 64'(k * 8), 64'h8000_0028, k[0], 64'h1111_2222_3333_4444, 8'hF0, 0);

      // IF response stalled 5 cycles while LS waits.
      txn(1, 1, 64'h8000_0018, 64'h8000_0030, 0, 0, 0, 5);

      // Randomized traffic over a small address pool so writes get read back.
      for (int n = 0; n < 40; n++)
         txn(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             64'h8000_0000 + 64'($urandom_range(0, 7) * 8),
             64'h8000_0000 + 64'($urandom_range(0, 7) * 8),
             bit'($urandom_range(0, 1)), {32'($urandom), 32'($urandom)},
             8'($urandom), $urandom_range(0, 3));

      // Reset asserted in WAIT aborts the transaction.
      bus.if_req_valid = 1'b1; bus.if_req_addr = 64'h8000_0038; bus.ls_req_valid = 1'b0;
      tick();
      bus.if_req_valid = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1 chk_all_zero("midrst");
      tick(); tick();
      rst_n = 1'b1;
      m_last_ls = 1'b1;
      for (int c = 0; c < 3; c++) begin
         chk("postrst_if_rv", bus.if_rsp_valid, 0);
         chk("postrst_ce", bus.mem_ce, 0);
         tick();
      end
      txn(1, 1, 64'h8000_0000, 64'h8000_0010, 0, 0, 0, 0);
      txn(1, 1, 64'h8000_0008, 64'h8000_0010, 0, 0, 0, 0);

      // Latency extremes on the LATENCY=0 and LATENCY=15 instances.
      a_w = 64'h8000_0040;
      b0.if_req_valid = 1'b1;  b0.if_req_addr = a_w;
      b15.if_req_valid = 1'b1; b15.if_req_addr = a_w;
      #1;
      chk("l0_rdy", b0.if_req_ready, 1);
      chk("l15_rdy", b15.if_req_ready, 1);
      tick();
      b0.if_req_valid = 1'b0; b15.if_req_valid = 1'b0;
      lat0 = -1; lat15 = -1; rd0 = '0; rd15 = '0;
      for (int c = 1; c <= 40; c++) begin
         if (b0.if_rsp_valid && lat0 < 0) begin lat0 = c; rd0 = b0.if_rsp_rdata; end
         if (b15.if_rsp_valid && lat15 < 0) begin lat15 = c; rd15 = b15.if_rsp_rdata; end
         tick();
      end
      chk("lat0_cycles", 64'(lat0), 64'd2);
      chk("lat15_cycles", 64'(lat15), 64'd17);
      chk("lat0_rdata", rd0, ~a_w);
      chk("lat15_rdata", rd15, ~a_w);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
